// File: rtl/global_bus_arbiter.sv
// rtl/global_bus_arbiter.sv - round-robin global bus gate arbiter with bounded hold and dead cycle
// Define GBUS_ARB_FIXED_PRIO_EN for fixed priority pc > mdr > adder > alu instead of round-robin.
module global_bus_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic       g_pc,
    output logic       g_mdr,
    output logic       g_adder,
    output logic       g_alu,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [3:0]       gate;
    logic             win_any;
    logic [1:0]       win_id;

`ifdef GBUS_ARB_FIXED_PRIO_EN
    always_comb begin
        win_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) win_id = 2'(i);
        end
    end
`else
    logic [1:0] rr_ptr;
    logic [1:0] idx;

    // Scan offsets from farthest to nearest so the first set bit after rr_ptr wins.
    always_comb begin
        win_id = 2'd0;
        idx    = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = rr_ptr + 2'(i);
            if (req[idx]) win_id = idx;
        end
    end
`endif

    assign win_any = |req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gate     <= 4'b0000;
            grant_id <= 2'd0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
            hold_cnt <= '0;
`ifndef GBUS_ARB_FIXED_PRIO_EN
            rr_ptr   <= 2'd3;
`endif
        end else begin
            preempt <= 1'b0;
            case (state)
                GRANT: begin
                    if (!req[grant_id]) begin
                        state <= GAP;
                        gate  <= 4'b0000;
                        busy  <= 1'b0;
                    end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
                        state   <= GAP;
                        gate    <= 4'b0000;
                        busy    <= 1'b0;
                        preempt <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and the single GAP cycle both arbitrate the same way.
                    if (win_any) begin
                        state    <= GRANT;
                        gate     <= 4'b0001 << win_id;
                        grant_id <= win_id;
                        busy     <= 1'b1;
                        hold_cnt <= CNT_W'(1);
`ifndef GBUS_ARB_FIXED_PRIO_EN
                        rr_ptr   <= win_id;
`endif
                    end else begin
                        state <= IDLE;
                        gate  <= 4'b0000;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign g_pc    = gate[0];
    assign g_mdr   = gate[1];
    assign g_adder = gate[2];
    assign g_alu   = gate[3];

endmodule
